// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues in-order word requests and
// buffers returned instructions in a prefetch queue drained by decode.
`timescale 1ns/1ps
module fetch_unit #(
    parameter int          XLEN        = 64,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [31:0]     q_instr [QUEUE_DEPTH];
    logic [XLEN-1:0] q_pc    [QUEUE_DEPTH];
    logic [XLEN-1:0] pf_pc   [QUEUE_DEPTH];
    logic [AW-1:0]   q_head, q_tail, pf_head, pf_tail;
    logic [CW-1:0]   count, inflight, discard, inflight_nxt;
    logic [CW:0]     used;
    logic            req_fire, resp_ok, enq, deq;

    assign used           = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = !reset && !redirect_valid
                            && (used < (CW+1)'(QUEUE_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored
    assign resp_ok = imem_resp_valid && (inflight != '0);
    assign enq     = resp_ok && !redirect_valid && (discard == '0);

    assign id_valid = (count != '0) && !redirect_valid;
    assign deq      = id_valid && id_ready;
    assign id_instr = (count != '0) ? q_instr[q_head] : NOP_INSTR;
    assign id_pc    = (count != '0) ? q_pc[q_head] : '0;

    assign inflight_nxt = inflight + CW'(req_fire) - CW'(resp_ok);

    always_ff @(posedge clk) begin
        if (enq) begin
            q_instr[q_tail] <= imem_resp_data;
            q_pc[q_tail]    <= pf_pc[pf_head];
        end
        if (req_fire)
            pf_pc[pf_tail] <= fetch_pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= XLEN'(RESET_PC);
            q_head   <= '0;
            q_tail   <= '0;
            pf_head  <= '0;
            pf_tail  <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (req_fire) begin
                pf_tail  <= pf_tail + AW'(1);
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (resp_ok)
                pf_head <= pf_head + AW'(1);
            // Everything still outstanding after this cycle belongs to the old stream
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~XLEN'(3);
                q_head   <= '0;
                q_tail   <= '0;
                count    <= '0;
                discard  <= inflight_nxt;
            end else begin
                if (resp_ok && discard != '0)
                    discard <= discard - CW'(1);
                if (enq)
                    q_tail <= q_tail + AW'(1);
                if (deq)
                    q_head <= q_head + AW'(1);
                count <= count + CW'(enq) - CW'(deq);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model.
`timescale 1ns/1ps
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [63:0] id_pc;

    int n_run  = 0;
    int n_fail = 0;
    int lat    = 1;
    int cyc    = 0;
    int nreq   = 0;
    int n0;
    logic [63:0] qa[$];
    int          qd[$];

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    // Memory: accepts on edge, answers lat cycles later, in order
    always @(posedge clk) begin
        if (!reset && imem_req_valid && imem_req_ready) begin
            qa.push_back(imem_req_addr);
            qd.push_back(cyc + lat);
            nreq++;
        end
        cyc++;
        #1;
        if (qd.size() > 0 && qd[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word(qa[0]);
            void'(qa.pop_front());
            void'(qd.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
        end
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_id_instr", 64'(id_instr), 64'h13);
        chk("rst_id_pc", id_pc, 64'h0);
        reset = 1'b0;
        #1;
        chk("first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("first_req_addr", imem_req_addr, 64'h0);

        // Streaming, 1-cycle memory
        @(negedge clk);
        chk("stream_c1_idle", 64'(id_valid), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stream_valid", 64'(id_valid), 64'd1);
            chk("stream_pc", id_pc, 64'(4 * i));
            chk("stream_instr", 64'(id_instr), 64'(word(64'(4 * i))));
        end

        // Backpressure fills the queue
        id_ready = 1'b0;
        do_reset();
        n0 = nreq;
        repeat (6) @(negedge clk);
        chk("bp_nreq", 64'(nreq - n0), 64'd4);
        chk("bp_req_valid", 64'(imem_req_valid), 64'd0);
        chk("bp_id_valid", 64'(id_valid), 64'd1);
        chk("bp_head_pc", id_pc, 64'h0);
        id_ready = 1'b1;
        @(negedge clk);
        chk("bp_pc4", id_pc, 64'h4);
        chk("bp_resume_valid", 64'(imem_req_valid), 64'd1);
        chk("bp_resume_addr", imem_req_addr, 64'h10);
        @(negedge clk);
        chk("bp_pc8", id_pc, 64'h8);
        @(negedge clk);
        chk("bp_pcC", id_pc, 64'hC);
        @(negedge clk);
        chk("bp_pc10", id_pc, 64'h10);
        chk("bp_instr10", 64'(id_instr), 64'(word(64'h10)));

        // Redirect with two stale requests in flight, 3-cycle memory
        lat = 3;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        #1;
        chk("rd_req_blocked", 64'(imem_req_valid), 64'd0);
        chk("rd_id_blocked", 64'(id_valid), 64'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("rd_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rd_req_addr", imem_req_addr, 64'h40);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rd_stale_dropped", 64'(id_valid), 64'd0);
        end
        @(negedge clk);
        chk("rd_tgt_valid", 64'(id_valid), 64'd1);
        chk("rd_tgt_pc", id_pc, 64'h40);
        chk("rd_tgt_instr", 64'(id_instr), 64'(word(64'h40)));
        @(negedge clk);
        chk("rd_next_pc", id_pc, 64'h44);

        // Misaligned target and address wrap
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("mis_valid", 64'(imem_req_valid), 64'd1);
        chk("mis_addr", imem_req_addr, 64'h100);
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr_top", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        chk("wrap_valid", 64'(imem_req_valid), 64'd1);
        chk("wrap_addr_zero", imem_req_addr, 64'h0);
        for (int k = 0; k < 10 && !id_valid; k++)
            @(negedge clk);
        chk("wrap_wait", 64'(id_valid), 64'd1);
        chk("wrap_pc_top", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        chk("wrap_pc_zero", id_pc, 64'h0);

        // Reset mid-stream with two requests in flight
        do_reset();
        @(negedge clk);
        @(negedge clk);
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        #1;
        chk("mid_rst_req", 64'(imem_req_valid), 64'd0);
        chk("mid_rst_id", 64'(id_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_restart_valid", 64'(imem_req_valid), 64'd1);
        chk("mid_restart_addr", imem_req_addr, 64'h0);
        @(negedge clk);
        chk("mid_late0_ignored", 64'(id_valid), 64'd0);
        @(negedge clk);
        chk("mid_late1_ignored", 64'(id_valid), 64'd0);
        imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_empty", 64'(id_valid), 64'd0);
        end
        @(negedge clk);
        chk("mid_pc0_valid", 64'(id_valid), 64'd1);
        chk("mid_pc0", id_pc, 64'h0);
        chk("mid_instr0", 64'(id_instr), 64'(word(64'h0)));
        @(negedge clk);
        chk("mid_pc4", id_pc, 64'h4);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RISC-V core, directly upstream of the IF/ID pipeline register and decode. It owns the fetch PC, issues in-order word requests to a variable-latency instruction memory, and buffers returned instructions in a small prefetch queue. Decode consumes the queue through a valid/ready handshake. Branch/jump redirects from decode flush the queue and squash stale in-flight responses.

## Interface
- XLEN, 64, PC/address width
- QUEUE_DEPTH, 4, prefetch queue entries and max outstanding requests (power of 2, ≥2)
- RESET_PC, 64'h0, fetch PC after reset
- NOP_INSTR, 32'h00000013, value driven on id_instr when queue empty

Reset: reset, asynchronous, active-high; clock clk.
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- imem_req_valid  out  1  request address valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_resp_valid  in  1  response returned (strictly in request order)
- imem_resp_data  in  32  instruction word
- redirect_valid  in  1  decode requests PC change (branch taken / jal)
- redirect_pc  in  XLEN  new fetch target
- id_valid  out  1  id_instr/id_pc valid
- id_ready  in  1  decode consumes entry
- id_instr  out  32  instruction at queue head
- id_pc  out  XLEN  PC of id_instr

## Operation
- State: fetch_pc, circular queue {instr, pc} with head/tail/count, inflight counter, discard counter, pc FIFO of outstanding request addresses (depth QUEUE_DEPTH).
- Request: imem_req_valid = !redirect_valid && (count + inflight < QUEUE_DEPTH); imem_req_addr = fetch_pc. On valid&&ready: inflight+1, push fetch_pc to pc FIFO, fetch_pc += 4 (mod 2^XLEN, 0xFFFF_FFFF_FFFF_FFFC wraps to 0).
- Response: pops pc FIFO, inflight−1. If discard>0: discard−1, data dropped. Else enqueue {imem_resp_data, popped pc}. Credit rule guarantees no overflow; response with inflight==0 is a protocol error, ignored.
- Dequeue: id_valid = (count>0) && !redirect_valid; id_instr/id_pc = head entry; handshake id_valid&&id_ready pops head. count == 0 → id_instr=NOP_INSTR, id_pc=0.
- Redirect (redirect_valid=1): no request issued, no dequeue; at edge: queue emptied, fetch_pc = {redirect_pc[XLEN-1:2],2'b00}, discard = inflight after this cycle's response accounting (a response arriving in the redirect cycle is itself dropped regardless of discard). Consecutive redirects: last wins, discard recomputed each cycle.
- Simultaneous enqueue and dequeue with count==QUEUE_DEPTH or 0: both occur, count unchanged / 1 respectively (empty queue: no bypass, response visible next cycle).

## Timing
- Reset values: fetch_pc=RESET_PC, count=inflight=discard=0, id_valid=0, id_instr=NOP_INSTR, id_pc=0, imem_req_valid=0 while reset high.
- First request asserted first cycle after reset deasserts, addr=RESET_PC.
- Request accepted cycle t, response cycle t+k (k≥1), id_valid at t+k+1. Min request-to-decode latency 2 cycles.
- Throughput 1 instr/cycle sustained when memory latency k ≤ QUEUE_DEPTH−1 and id_ready=1.
- Redirect at cycle r: first request to target at r+1; target instruction at decode no earlier than r+3.
- Reset mid-operation: all state cleared immediately; responses arriving after reset release with inflight==0 are ignored.
- All outputs except imem_req_valid and id_valid (which gate on redirect_valid) driven from registers.

## Test plan
- Reset: hold reset 3 cycles → imem_req_valid=0, id_valid=0, id_instr=0x00000013; release → imem_req_addr=0 first cycle.
- Streaming, 1-cycle memory, id_ready=1: id_pc sequence 0,4,8,12,… one per cycle from cycle 2, id_instr matches memory words.
- Backpressure: id_ready=0, 1-cycle memory → exactly 4 requests (0..0xC), imem_req_valid drops, queue full; id_ready=1 → 0,4,8,C drained in order, fetching resumes at 0x10.
- Redirect with 2 in flight (3-cycle memory): redirect_pc=0x40 → both stale responses dropped, next id_pc=0x40, then 0x44; no instruction from old stream reaches decode.
- Misaligned/wrap: redirect_pc=0x103 → imem_req_addr=0x100; redirect to 0xFFFF_FFFF_FFFF_FFFC → following request addr 0x0.
- Reset mid-stream with 2 in flight → queue empty, late responses ignored, fetch restarts at RESET_PC.
